// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register bridge.
//   state_t      : bridge FSM state encoding
//   DATA_W       : SPI byte / register data width
//   CMD_RW_BIT   : command-byte bit selecting read (1) or write (0)
//   TX_IDLE_BYTE : byte presented to the SPI device when no read data is ready
//   COUNT_MAX    : saturation value of the per-frame byte counter
package spi_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned CMD_RW_BIT = 7;

  localparam logic [DATA_W-1:0] TX_IDLE_BYTE = 8'hFF;
  localparam logic [DATA_W-1:0] COUNT_MAX    = 8'hFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    WR     = 3'd2,
    RD_REQ = 3'd3,
    RD_CAP = 3'd4,
    RD     = 3'd5
  } state_t;

endpackage

// File: rtl/spi_reg_bridge.sv
// SPI byte stream to register-bus bridge.
// The first byte of a frame is a command (bit 7: 1=read, 0=write; bits 6:0:
// start address). Write frames stream data bytes into consecutive addresses;
// read frames prefetch the addressed register into tx_data and advance on
// every dummy byte. All outputs are registered.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   frame_active          : high while SPI chip-select is asserted (clk domain)
//   rx_valid, rx_data     : received byte strobe and data
//   reg_addr/wdata/we/re  : register bus request
//   reg_rdata             : register read data, valid the cycle after reg_re
//   tx_data, tx_ready     : next byte to shift out and its valid flag
//   overrun               : sticky, byte arrived while a read fetch was in flight
//   frame_done            : one-cycle pulse when a frame ends
//   byte_count            : accepted bytes in the current frame (saturating)
module spi_reg_bridge
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_active,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              overrun,
  output logic              frame_done,
  output logic [DATA_W-1:0] byte_count
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              we_d;
  logic              re_d;
  logic [DATA_W-1:0] tx_data_d;
  logic              tx_ready_d;
  logic              overrun_d;
  logic              done_d;
  logic [DATA_W-1:0] count_d;
  logic              accept;

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_we     <= 1'b0;
      reg_re     <= 1'b0;
      tx_data    <= TX_IDLE_BYTE;
      tx_ready   <= 1'b0;
      overrun    <= 1'b0;
      frame_done <= 1'b0;
      byte_count <= '0;
    end else begin
      state_q    <= state_d;
      reg_addr   <= addr_d;
      reg_wdata  <= wdata_d;
      reg_we     <= we_d;
      reg_re     <= re_d;
      tx_data    <= tx_data_d;
      tx_ready   <= tx_ready_d;
      overrun    <= overrun_d;
      frame_done <= done_d;
      byte_count <= count_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    addr_d     = reg_addr;
    wdata_d    = reg_wdata;
    we_d       = 1'b0;
    re_d       = 1'b0;
    tx_data_d  = tx_data;
    tx_ready_d = 1'b0;
    overrun_d  = overrun;
    done_d     = 1'b0;
    count_d    = byte_count;
    accept     = 1'b0;

    // Post-increment the write address once the strobe has been issued.
    if (reg_we) begin
      addr_d = reg_addr + ADDR_W'(1);
    end

    if (!frame_active) begin
      // Chip-select released: drop any pending access, byte_count holds.
      done_d  = (state_q != IDLE);
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = CMD;
          overrun_d = 1'b0;
          count_d   = '0;
        end
        CMD: begin
          if (rx_valid) begin
            accept = 1'b1;
            addr_d = rx_data[ADDR_W-1:0];
            if (rx_data[CMD_RW_BIT]) begin
              state_d = RD_REQ;
              re_d    = 1'b1;
            end else begin
              state_d = WR;
            end
          end
        end
        WR: begin
          if (rx_valid) begin
            accept  = 1'b1;
            we_d    = 1'b1;
            wdata_d = rx_data;
          end
        end
        RD_REQ: begin
          state_d = RD_CAP;
          if (rx_valid) overrun_d = 1'b1;
        end
        RD_CAP: begin
          state_d    = RD;
          tx_data_d  = reg_rdata;
          tx_ready_d = 1'b1;
          if (rx_valid) overrun_d = 1'b1;
        end
        RD: begin
          if (rx_valid) begin
            // Dummy byte consumed the current data; fetch the next register.
            accept  = 1'b1;
            addr_d  = reg_addr + ADDR_W'(1);
            re_d    = 1'b1;
            state_d = RD_REQ;
          end else begin
            tx_ready_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Idle byte whenever no fetched data is on offer.
    if (state_d != RD) begin
      tx_data_d = TX_IDLE_BYTE;
    end

    if (accept && (byte_count != COUNT_MAX)) begin
      count_d = byte_count + DATA_W'(1);
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed self-checking bench for spi_reg_bridge.
module tb_spi_reg_bridge;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       frame_active;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       overrun;
  logic       frame_done;
  logic [7:0] byte_count;

  int n_checks = 0;
  int n_errors = 0;
  int we_cnt   = 0;
  int re_cnt   = 0;
  int we_base;
  int re_base;

  logic [7:0] mem [128];

  spi_reg_bridge #(.ADDR_W(7)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_active (frame_active),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_we       (reg_we),
    .reg_re       (reg_re),
    .reg_rdata    (reg_rdata),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .overrun      (overrun),
    .frame_done   (frame_done),
    .byte_count   (byte_count)
  );

  always #5 clk = ~clk;

  // Register file model: read data valid the cycle after reg_re.
  always @(posedge clk) begin
    if (reg_re) reg_rdata <= mem[reg_addr];
    if (reg_we) we_cnt <= we_cnt + 1;
    if (reg_re) re_cnt <= re_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was sampled.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic frame_start();
    frame_active = 1'b1;
    @(negedge clk);
  endtask

  task automatic frame_end(input string tag, input logic [7:0] exp_count);
    frame_active = 1'b0;
    @(negedge clk);
    check({tag, "_done_hi"}, 32'(frame_done), 32'd1);
    check({tag, "_count"}, 32'(byte_count), 32'(exp_count));
    @(negedge clk);
    check({tag, "_done_lo"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    foreach (mem[i]) mem[i] = 8'(i) ^ 8'h5A;
    mem[5] = 8'h3C;
    mem[6] = 8'h4D;
    reg_rdata    = 8'h00;
    reset_n      = 1'b0;
    frame_active = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_tx_data", 32'(tx_data), 32'hFF);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_addr", 32'(reg_addr), 32'd0);
    check("rst_we_re", 32'({reg_we, reg_re}), 32'd0);
    check("rst_status", 32'({overrun, frame_done, byte_count}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Write burst: 0x10, 0xAA, 0xBB
    we_base = we_cnt;
    frame_start();
    send_byte(8'h10);
    check("wr_no_we_cmd", 32'(reg_we), 32'd0);
    send_byte(8'hAA);
    check("wr1_we", 32'(reg_we), 32'd1);
    check("wr1_addr", 32'(reg_addr), 32'h10);
    check("wr1_data", 32'(reg_wdata), 32'hAA);
    send_byte(8'hBB);
    check("wr2_we", 32'(reg_we), 32'd1);
    check("wr2_addr", 32'(reg_addr), 32'h11);
    check("wr2_data", 32'(reg_wdata), 32'hBB);
    @(negedge clk);
    check("wr_we_pulse", 32'(reg_we), 32'd0);
    check("wr_addr_post", 32'(reg_addr), 32'h12);
    check("wr_we_count", 32'(we_cnt - we_base), 32'd2);
    check("wr_tx_idle", 32'({tx_ready, tx_data}), 32'h0FF);
    frame_end("wr", 8'd3);

    // Read burst: 0x85, then one dummy byte
    re_base = re_cnt;
    frame_start();
    send_byte(8'h85);
    check("rd_re", 32'(reg_re), 32'd1);
    check("rd_addr", 32'(reg_addr), 32'h05);
    check("rd_rdy_c1", 32'(tx_ready), 32'd0);
    @(negedge clk);
    check("rd_re_pulse", 32'(reg_re), 32'd0);
    check("rd_rdy_c2", 32'(tx_ready), 32'd0);
    @(negedge clk);
    check("rd_rdy_c3", 32'(tx_ready), 32'd1);
    check("rd_data0", 32'(tx_data), 32'h3C);
    send_byte(8'h00);
    check("rd_dummy_rdy", 32'(tx_ready), 32'd0);
    check("rd_dummy_tx", 32'(tx_data), 32'hFF);
    check("rd_re2", 32'(reg_re), 32'd1);
    check("rd_addr2", 32'(reg_addr), 32'h06);
    repeat (2) @(negedge clk);
    check("rd_rdy2", 32'(tx_ready), 32'd1);
    check("rd_data1", 32'(tx_data), 32'h4D);
    check("rd_re_count", 32'(re_cnt - re_base), 32'd2);
    check("rd_overrun", 32'(overrun), 32'd0);
    frame_end("rd", 8'd2);
    check("rd_tx_after", 32'({tx_ready, tx_data}), 32'h0FF);

    // Address wrap on write
    frame_start();
    send_byte(8'h7F);
    send_byte(8'h11);
    check("wrap_we1", 32'({reg_we, reg_addr, reg_wdata}), {17'd0, 1'b1, 7'h7F, 8'h11});
    send_byte(8'h22);
    check("wrap_we2", 32'({reg_we, reg_addr, reg_wdata}), {17'd0, 1'b1, 7'h00, 8'h22});
    @(negedge clk);
    frame_end("wrap", 8'd3);

    // Overrun: byte during RD_REQ
    re_base = re_cnt;
    frame_start();
    send_byte(8'h85);
    send_byte(8'h99);
    check("ovr_set", 32'(overrun), 32'd1);
    @(negedge clk);
    check("ovr_rdy", 32'({tx_ready, tx_data}), 32'h13C);
    check("ovr_re_count", 32'(re_cnt - re_base), 32'd1);
    frame_end("ovr", 8'd1);
    check("ovr_sticky", 32'(overrun), 32'd1);
    frame_start();
    check("ovr_clear", 32'(overrun), 32'd0);
    check("ovr_count_clr", 32'(byte_count), 32'd0);

    // Abort: frame drops on the same cycle as a write data byte
    we_base = we_cnt;
    send_byte(8'h20);
    rx_valid     = 1'b1;
    rx_data      = 8'h55;
    frame_active = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0;
    check("abort_no_we", 32'(reg_we), 32'd0);
    check("abort_done", 32'(frame_done), 32'd1);
    check("abort_count", 32'(byte_count), 32'd1);
    check("abort_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk);
    check("abort_done_lo", 32'(frame_done), 32'd0);
    check("abort_we_count", 32'(we_cnt - we_base), 32'd0);

    // byte_count saturation
    frame_start();
    send_byte(8'h00);
    for (int i = 0; i < 260; i++) send_byte(8'(i));
    check("sat_count", 32'(byte_count), 32'hFF);
    @(negedge clk);
    frame_end("sat", 8'hFF);

    // Reset mid-read, then reset release with frame_active high
    frame_start();
    send_byte(8'h85);
    repeat (2) @(negedge clk);
    check("rstrd_rdy", 32'({tx_ready, tx_data}), 32'h13C);
    #2 reset_n = 1'b0;
    #1;
    check("rstrd_tx_data", 32'(tx_data), 32'hFF);
    check("rstrd_tx_ready", 32'(tx_ready), 32'd0);
    check("rstrd_addr", 32'(reg_addr), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rstrel_state", 32'(dut.state_q), 32'(CMD));
    send_byte(8'h30);
    send_byte(8'h66);
    check("rstrel_we", 32'({reg_we, reg_addr, reg_wdata}), {17'd0, 1'b1, 7'h30, 8'h66});
    @(negedge clk);
    frame_end("rstrel", 8'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_bridge.md
SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, register address width; the command byte carries 7 address bits, so ADDR_W is fixed at 7.
REQ-002 SHALL have ports: clk  in  1  system clock, sole clock of the block.
REQ-003 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: frame_active  in  1  clk-synchronous level, high while the SPI chip-select is asserted.
REQ-005 SHALL have ports: rx_valid  in  1  one-cycle pulse, a received SPI byte is on rx_data.
REQ-006 SHALL have ports: rx_data  in  8  received byte, valid only with rx_valid.
REQ-007 SHALL have ports: reg_addr  out  7, reg_wdata  out  8, reg_we  out  1, reg_re  out  1  register bus toward the register file.
REQ-008 SHALL have ports: reg_rdata  in  8  read data, valid the cycle after reg_re.
REQ-009 SHALL have ports: tx_data  out  8, tx_ready  out  1  next byte for the SPI device to shift out.
REQ-010 SHALL have ports: overrun  out  1, frame_done  out  1, byte_count  out  8  status outputs.

Function
REQ-011 SHALL implement FSM states IDLE, CMD, WR, RD_REQ, RD_CAP, RD.
REQ-012 IDLE -> CMD when frame_active is high; any state -> IDLE the cycle frame_active is low, with the pending access discarded.
REQ-013 In CMD, the first rx_valid byte SHALL be decoded: bit7=1 read, bit7=0 write; bits[6:0] are loaded into reg_addr.
REQ-014 Write command: CMD -> WR; each rx_valid in WR SHALL produce reg_we high for exactly one cycle, on the cycle after rx_valid, with reg_wdata=rx_data and reg_addr set to the current address.
REQ-015 Write: reg_addr SHALL increment on the cycle after each reg_we; 0x7F wraps to 0x00.
REQ-016 Read command: CMD -> RD_REQ -> RD_CAP -> RD.
REQ-017 RD_REQ: reg_re SHALL be high for exactly one cycle.
REQ-018 RD_CAP: tx_data SHALL be loaded with reg_rdata and tx_ready set to 1.
REQ-019 In RD, each rx_valid (dummy byte) SHALL clear tx_ready, increment reg_addr (wrap 0x7F->0x00), and return to RD_REQ.
REQ-020 Read latency: tx_ready SHALL be high 3 cycles after the rx_valid that triggered the fetch.
REQ-021 rx_valid arriving in RD_REQ or RD_CAP SHALL be ignored and SHALL set overrun.
REQ-022 overrun SHALL be sticky and SHALL clear only on the IDLE->CMD transition.
REQ-023 byte_count SHALL count rx_valid pulses accepted in the frame, including the command byte, and SHALL saturate at 0xFF.
REQ-024 byte_count SHALL clear on IDLE->CMD.
REQ-025 frame_done SHALL pulse for one cycle on the cycle frame_active falls while the state is not IDLE; byte_count SHALL hold its value through that pulse.
REQ-026 rx_valid coincident with frame_active low SHALL be discarded: no reg_we and no count.
REQ-027 Outside RD/RD_CAP, tx_ready SHALL be 0 and tx_data SHALL hold 0xFF.
REQ-028 reg_we and reg_re SHALL never be high in the same cycle.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 On reset_n low, asynchronously: state=IDLE, reg_addr=0x00, reg_wdata=0x00, reg_we=0, reg_re=0, tx_data=0xFF, tx_ready=0, overrun=0, frame_done=0, byte_count=0x00.
REQ-031 Reset deasserted while frame_active is high SHALL enter CMD on the next cycle; the next byte is treated as a command.

Structure
REQ-032 FSM state encoding, command-bit position (7), and the idle tx byte 0xFF SHALL live in the shared package spi_pkg.
REQ-033 The block SHALL be flat; no sub-module, since the CDC of the SPI strobe lives in the upstream synchronizer.

Verification
REQ-034 Write burst: command 0x10, data 0xAA, 0xBB -> reg_we at addr 0x10 data 0xAA, then addr 0x11 data 0xBB; byte_count=3 at frame_done.
REQ-035 Read burst: command 0x85 with reg file[5]=0x3C, [6]=0x4D -> reg_re at 0x05; tx_data=0x3C with tx_ready 3 cycles later; after a dummy byte, tx_data=0x4D.
REQ-036 Wrap: write command 0x7F, two data bytes -> reg_we at 0x7F then 0x00.
REQ-037 Overrun: second rx_valid one cycle after a read command -> overrun=1 and only one reg_re; overrun clears at the next frame start.
REQ-038 Abort: frame_active drops on the same cycle as rx_valid in WR -> no reg_we, frame_done pulses, state=IDLE.
REQ-039 Reset: reset_n asserted mid-read -> tx_data=0xFF and tx_ready=0 immediately, with no clk edge required.
